// File: rtl/con_debounce.sv
// Button conditioner for the 2-bit counter: two-flop synchroniser, saturating
// debounce counter, and registered level / press-pulse / con-enable outputs.
module con_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int TOGGLE    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic con,
  output logic stable,
  output logic press
);

  localparam int CW = ($clog2(DB_CYCLES + 1) < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DLAST = CW'(DB_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] dcnt;
  logic          differ, upd;

  // upd marks the cycle on which stable takes the synchronised level
  assign differ = (s2 != stable);
  assign upd    = differ && (dcnt == DLAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt   <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      press <= upd && s2;
      if (!differ) begin
        dcnt <= '0;
      end else if (upd) begin
        stable <= s2;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  generate
    if (TOGGLE != 0) begin : g_toggle
      // only rising updates flip the enable; releases are ignored
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          con <= 1'b0;
        else if (upd && s2) con <= ~con;
      end
    end else begin : g_level
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)     con <= 1'b0;
        else if (upd) con <= s2;
      end
    end
  endgenerate

endmodule

// File: tb/tb_con_debounce.sv
// Scoreboard bench for con_debounce: toggle and level instances share btn/rst;
// a sample-history model predicts outputs each edge, a negedge monitor compares.
module tb_con_debounce;
  localparam int DB = 4;

  typedef struct packed {
    logic stable;
    logic press;
    logic con_t;
    logic con_l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  logic con_t, stable_t, press_t;
  logic con_l, stable_l, press_l;

  int errs = 0;
  int checks = 0;
  int npress = 0;
  exp_t sb[$];

  // model state
  logic          m_s1 = 0, m_s2 = 0, m_stable = 0, m_press = 0, m_con_t = 0, m_con_l = 0;
  logic [DB-1:0] hist = '0;

  always #50 clk = ~clk;

  con_debounce #(.DB_CYCLES(DB), .TOGGLE(1)) dut_t (
    .clk(clk), .rst(rst), .btn(btn), .con(con_t), .stable(stable_t), .press(press_t));
  con_debounce #(.DB_CYCLES(DB), .TOGGLE(0)) dut_l (
    .clk(clk), .rst(rst), .btn(btn), .con(con_l), .stable(stable_l), .press(press_l));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // stable flips once DB consecutive sampled s2 values all differ from it
  task automatic model_edge(input logic b, input logic r);
    logic upd;
    if (!r) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_press = 0; m_con_t = 0; m_con_l = 0; hist = '0;
    end else begin
      hist = {hist[DB-2:0], m_s2};
      upd = 1'b1;
      for (int i = 0; i < DB; i++) if (hist[i] == m_stable) upd = 1'b0;
      m_press = upd && m_s2;
      if (upd) begin
        m_stable = m_s2;
        m_con_l  = m_s2;
        if (m_s2) m_con_t = ~m_con_t;
        hist = '0;
        for (int i = 0; i < DB; i++) hist[i] = m_s2;
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
    sb.push_back('{m_stable, m_press, m_con_t, m_con_l});
  endtask

  task automatic step(input logic b, input logic r);
    @(negedge clk);
    #1;
    btn = b;
    rst = r;
    if (!r) begin
      #1;
      chk("async_rst", {29'd0, stable_t, press_t, con_t}, 32'd0);
    end
    @(posedge clk);
    #1;
    model_edge(b, r);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stable", {31'd0, stable_t}, {31'd0, e.stable});
      chk("press", {31'd0, press_t}, {31'd0, e.press});
      chk("con_tog", {31'd0, con_t}, {31'd0, e.con_t});
      chk("con_lvl", {31'd0, con_l}, {31'd0, e.con_l});
      chk("lvl_eq_stable", {31'd0, con_l}, {31'd0, stable_l});
      chk("dcnt_range", {31'd0, (dut_t.dcnt <= 3'(DB - 1))}, 32'd1);
      if (press_t) npress++;
    end
  end

  initial begin
    int p0;
    int len;
    logic lvl;

    // reset held with btn high, then release
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1);
      if (i == 5 || i == 6) chk("rel_latency", {31'd0, stable_t}, (i >= 6) ? 32'd1 : 32'd0);
    end

    // release, then clean press/release
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    p0 = npress;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("clean_presses", npress - p0, 32'd1);

    // bounce rejection
    p0 = npress;
    for (int i = 0; i < 6; i++) step(i[0] ? 1'b0 : 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    chk("bounce_presses", npress - p0, 32'd0);

    // three toggle presses
    p0 = npress;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    end
    chk("toggle_presses", npress - p0, 32'd3);

    // reset mid-debounce
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1);
      if (i == 5 || i == 6) chk("midrst_latency", {31'd0, stable_t}, (i >= 6) ? 32'd1 : 32'd0);
    end

    // random runs of varied length, including sub-threshold glitches
    lvl = 1'b0;
    for (int n = 0; n < 40; n++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) step(lvl, 1'b1);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
